array_adjust_engine: RTL and testbench
======================================

// Module: array_adjust_engine
// PURPOSE
//  Parametrised memory-walk engine. Reads LENGTH words starting at BASE from a
//  single-port sync-read memory, compares each word to THRESHOLD, writes back
//  word-DELTA or word+DELTA, and counts words above THRESHOLD.
//  Replaces fixed-depth, fixed-constant walk controllers. Has a start/done handshake
//  and an integrated address/element datapath.
// PARAMETERS
//  DATA_W     8    memory word width
//  ADDR_W     8    memory address width (depth 2**ADDR_W)
//  THRESHOLD  109  compare constant, unsigned, DATA_W bits
//  DELTA      13   adjust constant, unsigned, DATA_W bits
// PORTS
//  clock      in   1         rising-edge clock
//  reset      in   1         synchronous, active-high
//  start      in   1         1-cycle request; sampled only in IDLE
//  base_addr  in   ADDR_W    first address, latched on accepted start
//  length     in   ADDR_W+1  word count 0..2**ADDR_W, latched on accepted start
//  mode       in   1         0: >TH subtract, else add; 1: >TH add, else subtract
//  mem_rdata  in   DATA_W    memory read data, 1-cycle latency after mem_addr
//  mem_addr   out  ADDR_W    registered memory address
//  mem_wdata  out  DATA_W    registered write data
//  mem_we     out  1         write strobe, 1 cycle per word
//  busy       out  1         high from cycle after accepted start until DONE
//  done       out  1         1-cycle pulse at end of run
//  hi_count   out  ADDR_W+1  words > THRESHOLD in last run; held until next start
// BEHAVIOUR
//  Clock and reset: one clock; reset is synchronous and active-high.
//  Reset: state=IDLE. All outputs 0: mem_addr, mem_wdata, mem_we, busy, done,
//   hi_count.
//  Reset mid-run: abort with no further write, next state IDLE, no done pulse.
//  States and transitions:
//   IDLE  : start=1 -> latch base/len/mode, clear hi_count;
//           len==0 -> DONE, else ADDR.
//   ADDR  : mem_addr<=ptr -> WAIT
//   WAIT  : memory samples address -> READ
//   READ  : elem<=mem_rdata -> CMP
//   CMP   : gt=(elem>THRESHOLD); hi_count+=gt; mem_wdata<=adjusted -> WRITE
//   WRITE : mem_we=1 for this cycle, mem_addr held -> NEXT
//   NEXT  : ptr<=ptr+1 mod 2**ADDR_W; remaining-=1; remaining==1 -> DONE, else ADDR
//   DONE  : done=1, busy=0 -> IDLE
//  Timing: 6 cycles per word; a run of N words takes 6N+1 cycles from the start edge
//   to the done pulse. A 0-length run pulses done 1 cycle after start.
//  start while busy or in DONE: ignored, no queueing.
//  Address wrap: base+len beyond 2**ADDR_W-1 wraps to 0.
//   len=2**ADDR_W touches every word exactly once.
//  Compare is strict >. elem==THRESHOLD takes the "else" branch.
//  Arithmetic is DATA_W bits wide. Overflow handling depends on configuration.
// CONFIGURATION
//  ADJ_SATURATE_EN defined:   add clamps to 2**DATA_W-1; subtract clamps to 0.
//  ADJ_SATURATE_EN undefined: add and subtract wrap modulo 2**DATA_W.
// TESTING
//  1. mem[0..3]={200,109,0,110}, base=0, len=4, mode=0 -> mem={187,122,13,97};
//     hi_count=2; done 25 cycles after start.
//  2. mem[254]=250, mem[255]=5, mem[0]=120, base=254, len=3, mode=1 ->
//     non-sat: {7,248,133}; ADJ_SATURATE_EN: {255,0,133}; address wraps 255->0.
//  3. len=0 -> done pulse 1 cycle after start; mem_we never asserted; hi_count=0.
//  4. start re-pulsed during run of len=2 -> ignored; exactly 2 writes; single done.
//  5. reset asserted in WRITE-1 (CMP) of word 1 -> mem_we stays 0; IDLE; busy=0;
//     no done; fresh start runs normally.
//  6. len=256, ADDR_W=8, all words 109 -> every word becomes 122; hi_count=0;
//     256 writes.

Source files
------------

// File: rtl/array_adjust_engine.sv
// array_adjust_engine: walks LENGTH words from BASE in a sync-read memory,
// adjusting each by +/-DELTA around THRESHOLD and counting words above it.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start               one-cycle request, only honoured while idle
//   base_addr, length   first address and word count (0..2**ADDR_W)
//   mode                0: above-threshold words subtract, others add
//                       1: above-threshold words add, others subtract
//   mem_rdata           memory read data, one cycle after mem_addr
//   mem_addr, mem_wdata, mem_we  registered memory command outputs
//   busy, done          run in progress / one-cycle end-of-run pulse
//   hi_count            words above THRESHOLD in the last run
//
// Build option: define ADJ_SATURATE_EN to clamp results to 0 / 2**DATA_W-1.
// Without it, add and subtract wrap modulo 2**DATA_W.

module array_adjust_engine #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter logic [DATA_W-1:0] THRESHOLD = DATA_W'(109),
    parameter logic [DATA_W-1:0] DELTA     = DATA_W'(13)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              mode,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   hi_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_READ,
        S_CMP,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] elem_q, elem_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W:0]   hi_count_q, hi_count_d;

    // Adjustment datapath, one extra bit to catch carry / borrow.
    logic              gt;
    logic              do_add;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] adj;

    always_comb begin
        gt     = (elem_q > THRESHOLD);
        do_add = mode_q ? gt : ~gt;
        sum    = {1'b0, elem_q} + {1'b0, DELTA};
        diff   = {1'b0, elem_q} - {1'b0, DELTA};
`ifdef ADJ_SATURATE_EN
        if (do_add) begin
            adj = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
        end else begin
            // diff[DATA_W] set means the subtraction borrowed.
            adj = diff[DATA_W] ? {DATA_W{1'b0}} : diff[DATA_W-1:0];
        end
`else
        adj = do_add ? sum[DATA_W-1:0] : diff[DATA_W-1:0];
`endif
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        mode_d      = mode_q;
        elem_d      = elem_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        hi_count_d  = hi_count_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d       = base_addr;
                    remaining_d = length;
                    mode_d      = mode;
                    hi_count_d  = '0;
                    busy_d      = 1'b1;
                    state_d     = (length == '0) ? S_DONE : S_ADDR;
                end
            end
            S_ADDR: begin
                mem_addr_d = ptr_q;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_READ;
            end
            S_READ: begin
                elem_d  = mem_rdata;
                state_d = S_CMP;
            end
            S_CMP: begin
                hi_count_d  = hi_count_q + {{ADDR_W{1'b0}}, gt};
                mem_wdata_d = adj;
                // Registered strobe: high during the WRITE cycle.
                mem_we_d    = 1'b1;
                state_d     = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_NEXT;
            end
            S_NEXT: begin
                ptr_d       = ptr_q + 1'b1;
                remaining_d = remaining_q - 1'b1;
                state_d     = (remaining_q == {{ADDR_W{1'b0}}, 1'b1})
                              ? S_DONE : S_ADDR;
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            mode_q      <= 1'b0;
            elem_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hi_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            mode_q      <= mode_d;
            elem_q      <= elem_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            hi_count_q  <= hi_count_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign hi_count  = hi_count_q;

endmodule

// File: tb/tb_array_adjust_engine.sv
// tb_array_adjust_engine: directed and random runs of array_adjust_engine
// against a word-level reference model and a bench-owned memory.

module tb_array_adjust_engine;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 256;
    localparam int TH    = 109;
    localparam int DL    = 13;

    logic          clock;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          mode;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          busy;
    logic          done;
    logic [AW:0]   hi_count;

    logic          tb_we;
    logic [AW-1:0] tb_addr;
    logic [DW-1:0] tb_wdata;

    logic [DW-1:0] mem [DEPTH];
    int            exp_mem [DEPTH];

    int total = 0;
    int bad   = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;

    array_adjust_engine dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .mode      (mode),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .busy      (busy),
        .done      (done),
        .hi_count  (hi_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port sync-read memory; bench preload port has priority.
    always @(posedge clock) begin
        if (tb_we) mem[tb_addr] <= tb_wdata;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    always @(posedge clock) begin
        if (mem_we) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Word-level model: applies one run to exp_mem, returns count above TH.
    function automatic int ref_run(int b, int l, bit md);
        int hi = 0;
        for (int i = 0; i < l; i++) begin
            int a = (b + i) % DEPTH;
            int v = exp_mem[a];
            bit g = (v > TH);
            bit add = md ? g : !g;
            int r = add ? v + DL : v - DL;
`ifdef ADJ_SATURATE_EN
            if (r > 255) r = 255;
            if (r < 0) r = 0;
`else
            r = (r + 256) % 256;
`endif
            exp_mem[a] = r;
            if (g) hi++;
        end
        return hi;
    endfunction

    task automatic poke(input int a, input int v);
        @(negedge clock);
        tb_we = 1'b1;
        tb_addr = AW'(a);
        tb_wdata = DW'(v);
        @(posedge clock);
        #1 tb_we = 1'b0;
        exp_mem[a] = v;
    endtask

    task automatic cmp_mem(input string tag);
        for (int a = 0; a < DEPTH; a++)
            chk($sformatf("%s mem[%0d]", tag, a), 32'(mem[a]), exp_mem[a]);
    endtask

    // One run; pulse_at >= 0 re-asserts start that many edges after the
    // accepted start edge, which must be ignored.
    task automatic run(input string tag, input int b, input int l,
                       input bit md, input int pulse_at);
        int w0 = wr_cnt;
        int d0 = done_cnt;
        int cyc = 0;
        int hi = ref_run(b, l, md);
        @(negedge clock);
        base_addr = AW'(b);
        length = 9'(l);
        mode = md;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        chk({tag, " busy"}, 32'(busy), 1);
        while (done !== 1'b1 && cyc < 2000) begin
            @(posedge clock);
            cyc++;
            #1 start = (cyc == pulse_at);
            if (cyc == pulse_at) length = 9'd7;
            @(negedge clock);
        end
        start = 1'b0;
        chk({tag, " cycles"}, cyc, 6 * l + 1);
        chk({tag, " busy_at_done"}, 32'(busy), 0);
        chk({tag, " hi_count"}, 32'(hi_count), hi);
        @(negedge clock);
        chk({tag, " done_pulse"}, 32'(done), 0);
        chk({tag, " writes"}, wr_cnt - w0, l);
        chk({tag, " dones"}, done_cnt - d0, 1);
        cmp_mem(tag);
    endtask

    initial begin
        int w0;
        int d0;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        mode = 1'b0;
        tb_we = 1'b0;
        tb_addr = '0;
        tb_wdata = '0;
        reset = 1'b1;
        for (int a = 0; a < DEPTH; a++) exp_mem[a] = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst mem_addr", 32'(mem_addr), 0);
        chk("rst mem_wdata", 32'(mem_wdata), 0);
        chk("rst mem_we", 32'(mem_we), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst hi_count", 32'(hi_count), 0);
        reset = 1'b0;
        for (int a = 0; a < DEPTH; a++) poke(a, 0);

        // Basic walk with threshold boundaries.
        poke(0, 200); poke(1, 109); poke(2, 0); poke(3, 110);
        run("t1", 0, 4, 1'b0, -1);
        chk("t1 w0", 32'(mem[0]), 187);
        chk("t1 w1", 32'(mem[1]), 122);
        chk("t1 w2", 32'(mem[2]), 13);
        chk("t1 w3", 32'(mem[3]), 97);
        chk("t1 hi", 32'(hi_count), 2);

        // Address wrap and overflow handling.
        poke(254, 250); poke(255, 5); poke(0, 120);
        run("t2", 254, 3, 1'b1, -1);
`ifdef ADJ_SATURATE_EN
        chk("t2 w254", 32'(mem[254]), 255);
        chk("t2 w255", 32'(mem[255]), 0);
`else
        chk("t2 w254", 32'(mem[254]), 7);
        chk("t2 w255", 32'(mem[255]), 248);
`endif
        chk("t2 w0", 32'(mem[0]), 133);

        // Zero-length run.
        run("t3", 17, 0, 1'b0, -1);
        chk("t3 hi", 32'(hi_count), 0);

        // Start pulses while busy and while in DONE.
        run("t4a", 40, 2, 1'b0, 3);
        run("t4b", 40, 2, 1'b1, 12);

        // Reset during the compare cycle of the second word.
        poke(10, 50); poke(11, 200); poke(12, 60); poke(13, 70);
        w0 = wr_cnt;
        d0 = done_cnt;
        void'(ref_run(10, 1, 1'b0));
        @(negedge clock);
        base_addr = 8'd10;
        length = 9'd4;
        mode = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (9) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("t5 busy", 32'(busy), 0);
        chk("t5 mem_we", 32'(mem_we), 0);
        chk("t5 hi", 32'(hi_count), 0);
        repeat (10) @(posedge clock);
        @(negedge clock);
        chk("t5 writes", wr_cnt - w0, 1);
        chk("t5 dones", done_cnt - d0, 0);
        cmp_mem("t5");
        run("t5 rerun", 10, 4, 1'b0, -1);

        // Full-depth run, every word at the threshold.
        for (int a = 0; a < DEPTH; a++) poke(a, TH);
        run("t6", 0, 256, 1'b0, -1);
        chk("t6 w0", 32'(mem[0]), 122);
        chk("t6 w255", 32'(mem[255]), 122);

        // Random runs with values biased toward the interesting edges.
        for (int k = 0; k < 14; k++) begin
            int b = $urandom_range(0, 255);
            int l = (k == 13) ? 256 : $urandom_range(0, 40);
            bit md = 1'($urandom_range(0, 1));
            int span = (l > 48) ? 48 : l;
            for (int i = 0; i < span; i++) begin
                int pick = $urandom_range(0, 9);
                int v;
                case (pick)
                    0: v = 108;
                    1: v = 109;
                    2: v = 110;
                    3: v = 0;
                    4: v = 255;
                    5: v = 12;
                    6: v = 243;
                    default: v = $urandom_range(0, 255);
                endcase
                poke((b + i) % DEPTH, v);
            end
            run($sformatf("rnd%0d", k), b, l, md, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
